// File: rtl/iob_axi_ram_slave.sv
// AXI4 responder backed by an internal dual-port RAM: independent read and write engines,
// one outstanding transaction per direction, FIXED/INCR bursts, every beat full width.
module iob_axi_ram_slave #(
   parameter int AXI_ID_W   = 1,
   parameter int AXI_ADDR_W = 24,
   parameter int AXI_DATA_W = 32,
   parameter int AXI_LEN_W  = 8,
   parameter int MEM_ADDR_W = 10
) (
   input  logic                    clk_i,
   input  logic                    arst_n_i,
   input  logic [AXI_ID_W-1:0]     axi_awid_i,
   input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
   input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
   input  logic [2:0]              axi_awsize_i,
   input  logic [1:0]              axi_awburst_i,
   input  logic                    axi_awvalid_i,
   output logic                    axi_awready_o,
   input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
   input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
   input  logic                    axi_wlast_i,
   input  logic                    axi_wvalid_i,
   output logic                    axi_wready_o,
   output logic [AXI_ID_W-1:0]     axi_bid_o,
   output logic [1:0]              axi_bresp_o,
   output logic                    axi_bvalid_o,
   input  logic                    axi_bready_i,
   input  logic [AXI_ID_W-1:0]     axi_arid_i,
   input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
   input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
   input  logic [2:0]              axi_arsize_i,
   input  logic [1:0]              axi_arburst_i,
   input  logic                    axi_arvalid_i,
   output logic                    axi_arready_o,
   output logic [AXI_ID_W-1:0]     axi_rid_o,
   output logic [AXI_DATA_W-1:0]   axi_rdata_o,
   output logic [1:0]              axi_rresp_o,
   output logic                    axi_rlast_o,
   output logic                    axi_rvalid_o,
   input  logic                    axi_rready_i
);

   localparam int NB_W  = $clog2(AXI_DATA_W / 8);
   localparam int NSTRB = AXI_DATA_W / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;

   // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1.
   // Our valid/ready outputs depend on registered state only, and payloads hold while valid.

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

   w_state_t w_state, w_state_nxt;
   r_state_t r_state, r_state_nxt;

   logic                  ready_en;
   logic                  aw_hs, w_hs, b_hs, w_end;
   logic                  ar_hs, r_hs, r_last;
   logic [AXI_ID_W-1:0]   w_id, r_id;
   logic [MEM_ADDR_W-1:0] w_addr, r_addr;
   logic [AXI_LEN_W-1:0]  w_len, w_cnt, r_len, r_cnt;
   logic                  w_fixed, r_fixed;
   logic [1:0]            w_resp;
   logic [AXI_DATA_W-1:0] rdata_q;
   logic [AXI_DATA_W-1:0] mem [0:(1<<MEM_ADDR_W)-1];
   logic                  unused_bits;

   assign unused_bits = ^{axi_awsize_i, axi_arsize_i, axi_awaddr_i, axi_araddr_i};

   // Keeps awready/arready low until the first edge after reset release.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) ready_en <= 1'b0;
      else           ready_en <= 1'b1;
   end

   // ---------------- write engine ----------------
   assign aw_hs = axi_awvalid_i & axi_awready_o;
   assign w_hs  = axi_wvalid_i & axi_wready_o;
   assign b_hs  = axi_bvalid_o & axi_bready_i;
   assign w_end = axi_wlast_i | (w_cnt == w_len);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) w_state <= W_IDLE;
      else           w_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs)          w_state_nxt = W_DATA;
         W_DATA:  if (w_hs && w_end)  w_state_nxt = W_RESP;
         W_RESP:  if (b_hs)           w_state_nxt = W_IDLE;
         default:                     w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      axi_awready_o = 1'b0;
      axi_wready_o  = 1'b0;
      axi_bvalid_o  = 1'b0;
      case (w_state)
         W_IDLE:  axi_awready_o = ready_en;
         W_DATA:  axi_wready_o  = 1'b1;
         W_RESP:  axi_bvalid_o  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         w_id    <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_cnt   <= '0;
         w_fixed <= 1'b0;
         w_resp  <= RESP_OKAY;
      end else if (aw_hs) begin
         w_id    <= axi_awid_i;
         w_addr  <= axi_awaddr_i[MEM_ADDR_W+NB_W-1:NB_W];
         w_len   <= axi_awlen_i;
         w_fixed <= (axi_awburst_i == BURST_FIXED);
         w_cnt   <= '0;
      end else if (w_hs) begin
         if (!w_fixed) w_addr <= w_addr + MEM_ADDR_W'(1);
         if (!w_end)   w_cnt  <= w_cnt + AXI_LEN_W'(1);
         // OKAY only when the master's wlast lands exactly on the announced length
         if (w_end)    w_resp <= (axi_wlast_i && (w_cnt == w_len)) ? RESP_OKAY : RESP_SLVERR;
      end
   end

   assign axi_bid_o   = w_id;
   assign axi_bresp_o = w_resp;

   always_ff @(posedge clk_i) begin
      if (w_hs) begin
         for (int b = 0; b < NSTRB; b++) begin
            if (axi_wstrb_i[b]) mem[w_addr][8*b +: 8] <= axi_wdata_i[8*b +: 8];
         end
      end
   end

   // ---------------- read engine ----------------
   assign ar_hs  = axi_arvalid_i & axi_arready_o;
   assign r_hs   = axi_rvalid_o & axi_rready_i;
   assign r_last = (r_cnt == r_len);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) r_state <= R_IDLE;
      else           r_state <= r_state_nxt;
   end

   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_state_nxt = R_FETCH;
         R_FETCH:            r_state_nxt = R_DATA;
         R_DATA:  if (r_hs)  r_state_nxt = r_last ? R_IDLE : R_FETCH;
         default:            r_state_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      axi_arready_o = 1'b0;
      axi_rvalid_o  = 1'b0;
      axi_rlast_o   = 1'b0;
      case (r_state)
         R_IDLE:  axi_arready_o = ready_en;
         R_DATA: begin
            axi_rvalid_o = 1'b1;
            axi_rlast_o  = r_last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_fixed <= 1'b0;
      end else if (ar_hs) begin
         r_id    <= axi_arid_i;
         r_addr  <= axi_araddr_i[MEM_ADDR_W+NB_W-1:NB_W];
         r_len   <= axi_arlen_i;
         r_fixed <= (axi_arburst_i == BURST_FIXED);
         r_cnt   <= '0;
      end else if (r_hs && !r_last) begin
         if (!r_fixed) r_addr <= r_addr + MEM_ADDR_W'(1);
         r_cnt <= r_cnt + AXI_LEN_W'(1);
      end
   end

   // Registered read port; a write to the same word on the fetch edge leaves the old value here.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i)              rdata_q <= '0;
      else if (r_state == R_FETCH) rdata_q <= mem[r_addr];
   end

   assign axi_rid_o   = r_id;
   assign axi_rdata_o = rdata_q;
   assign axi_rresp_o = RESP_OKAY;

endmodule

// File: tb/tb_iob_axi_ram_slave.sv
// Randomised and directed bench for iob_axi_ram_slave against a transaction-level memory model
// that follows every handshake on the bus and predicts each R and B payload.
module tb_iob_axi_ram_slave;

   localparam int ID_W  = 1;
   localparam int DEPTH = 1024;
   localparam int TMO   = 4000;

   logic        clk, arst_n;
   logic [0:0]  awid, arid, bid, rid;
   logic [23:0] awaddr, araddr;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rlast, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;

   iob_axi_ram_slave dut (
      .clk_i(clk), .arst_n_i(arst_n),
      .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
      .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
      .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
      .axi_wvalid_i(wvalid), .axi_wready_o(wready),
      .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
      .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
      .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
      .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
      .axi_rvalid_o(rvalid), .axi_rready_i(rready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0]     model_mem [DEPTH];
   logic [ID_W+1:0] exp_q[$];
   bit              m_w_active, m_r_active, r_have, pend_w;
   int              m_w_word, m_w_len, m_w_cnt, m_r_word, m_r_len, m_r_cnt;
   logic [1:0]      m_w_burst, m_r_burst;
   logic [0:0]      m_w_id, m_r_id;
   logic [31:0]     r_exp, pend_data;
   logic [3:0]      pend_strb;
   int              pend_word;

   function automatic int word_of(input logic [23:0] a);
      return (int'(a) >> 2) % DEPTH;
   endfunction

   function automatic int next_word(input int w, input logic [1:0] burst);
      return (burst == 2'b00) ? w : (w + 1) % DEPTH;
   endfunction

   task automatic apply_pending();
      if (pend_w) begin
         for (int b = 0; b < 4; b++)
            if (pend_strb[b]) model_mem[pend_word][8*b +: 8] = pend_data[8*b +: 8];
         pend_w = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (!arst_n) begin
         apply_pending();
         m_w_active = 0; m_r_active = 0; r_have = 0;
         exp_q.delete();
         check("reset_outputs", {awready, wready, bvalid, arready, rvalid, rlast,
                                 bid, bresp, rid, rresp, rdata}, 64'd0);
      end else begin
         if (rvalid && !m_r_active) check("r_unexpected", rvalid, 0);
         if (rvalid && m_r_active) begin
            // the beat's word is sampled from memory as it stood before its fetch edge
            if (!r_have) begin r_exp = model_mem[m_r_word]; r_have = 1; end
            check("rdata", rdata, r_exp);
            check("rlast", rlast, (m_r_cnt == m_r_len));
            check("rid", rid, m_r_id);
            check("rresp", rresp, 2'b00);
            if (rready) begin
               r_have = 0;
               if (m_r_cnt == m_r_len) m_r_active = 0;
               else begin m_r_cnt++; m_r_word = next_word(m_r_word, m_r_burst); end
            end
         end
         if (bvalid && exp_q.size() == 0) check("b_unexpected", bvalid, 0);
         if (bvalid && exp_q.size() != 0) begin
            check("bid_bresp", {bid, bresp}, exp_q[0]);
            if (bready) void'(exp_q.pop_front());
         end
         apply_pending();
         if (arvalid && arready) begin
            m_r_active = 1; m_r_word = word_of(araddr); m_r_len = int'(arlen);
            m_r_burst = arburst; m_r_id = arid; m_r_cnt = 0; r_have = 0;
         end
         if (awvalid && awready) begin
            m_w_active = 1; m_w_word = word_of(awaddr); m_w_len = int'(awlen);
            m_w_burst = awburst; m_w_id = awid; m_w_cnt = 0;
         end
         if (wvalid && wready && !m_w_active) check("w_unexpected", wready, 0);
         if (wvalid && wready && m_w_active) begin
            pend_w = 1; pend_word = m_w_word; pend_data = wdata; pend_strb = wstrb;
            if (wlast || m_w_cnt == m_w_len) begin
               exp_q.push_back({m_w_id, (wlast && m_w_cnt == m_w_len) ? 2'b00 : 2'b10});
               m_w_active = 0;
            end else begin
               m_w_cnt++; m_w_word = next_word(m_w_word, m_w_burst);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   logic [31:0] wbuf [256];
   logic [3:0]  sbuf [256];
   logic [31:0] rbuf [256];
   logic        rlast_buf [256];
   logic [0:0]  b_id_got;
   logic [1:0]  b_resp_got;

   task automatic do_write(input logic [0:0] id, input logic [23:0] addr, input int len,
                           input logic [1:0] burst, input int nbeats, input int wlast_idx,
                           input bit gaps);
      int t;
      bit first, done;
      awid = id; awaddr = addr; awlen = len[7:0]; awsize = 3'd2; awburst = burst; awvalid = 1;
      t = 0;
      do begin @(negedge clk); t++; end while (!awready && t < TMO);
      if (!awready) begin check("aw_timeout", awready, 1); awvalid = 0; return; end
      @(posedge clk); #1 awvalid = 0;
      @(negedge clk); check("wready_after_aw", wready, 1);
      @(posedge clk); #1;
      for (int i = 0; i < nbeats; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         wvalid = 1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == wlast_idx);
         t = 0;
         do begin @(negedge clk); t++; end while (!wready && t < TMO);
         if (!wready) begin check("w_timeout", wready, 1); wvalid = 0; wlast = 0; return; end
         @(posedge clk); #1 wvalid = 0; wlast = 0;
      end
      first = 1; done = 0; t = 0;
      while (!done && t < TMO) begin
         bready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (first) begin check("bvalid_after_last", bvalid, 1); first = 0; end
         if (bvalid && bready) begin b_id_got = bid; b_resp_got = bresp; done = 1; end
         @(posedge clk); #1; t++;
      end
      bready = 0;
      if (!done) check("b_timeout", bvalid, 1);
   endtask

   task automatic do_read(input logic [0:0] id, input logic [23:0] addr, input int len,
                          input logic [1:0] burst, input bit rdy_rand);
      int t, beat;
      bit first, just_hs;
      arid = id; araddr = addr; arlen = len[7:0]; arsize = 3'd2; arburst = burst; arvalid = 1;
      t = 0;
      do begin @(negedge clk); t++; end while (!arready && t < TMO);
      if (!arready) begin check("ar_timeout", arready, 1); arvalid = 0; return; end
      @(posedge clk); #1 arvalid = 0;
      @(negedge clk); check("rvalid_latency1", rvalid, 0);
      beat = 0; first = 1; just_hs = 0; t = 0;
      while (beat <= len && t < TMO) begin
         @(posedge clk); #1 rready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         if (first) begin check("rvalid_latency2", rvalid, 1); first = 0; end
         if (just_hs) begin check("r_beat_gap", rvalid, 0); just_hs = 0; end
         if (rvalid && rready) begin
            rbuf[beat] = rdata; rlast_buf[beat] = rlast; beat++; just_hs = 1;
         end
         t++;
      end
      @(posedge clk); #1 rready = 0;
      if (beat <= len) check("r_timeout", rvalid, 1);
      else begin @(negedge clk); check("rvalid_after_last", rvalid, 0); @(posedge clk); #1; end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t;
      arst_n = 1; awvalid = 0; wvalid = 0; wlast = 0; bready = 0; arvalid = 0; rready = 0;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
      #1 arst_n = 0;
      repeat (3) @(posedge clk);
      #1 arst_n = 1;
      @(negedge clk); check("ready_before_first_edge", {awready, arready}, 2'b00);
      @(posedge clk); #1;
      @(negedge clk); check("ready_after_first_edge", {awready, arready}, 2'b11);
      @(posedge clk); #1;

      // whole RAM to a known random image
      for (int blk = 0; blk < 4; blk++) begin
         for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
         do_write(0, 24'(blk * 1024), 255, 2'b01, 256, 255, 0);
      end

      // single write / read
      wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
      do_write(1, 24'h10, 0, 2'b01, 1, 0, 0);
      check("t1_bid", b_id_got, 1'b1);
      check("t1_bresp", b_resp_got, 2'b00);
      check("t1_model_pin", model_mem[4], 32'hDEADBEEF);
      do_read(1, 24'h10, 0, 2'b01, 0);
      check("t1_rdata", rbuf[0], 32'hDEADBEEF);
      check("t1_rlast", rlast_buf[0], 1'b1);

      // 8-beat INCR with partial strobes over an all-ones region
      for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hFFFFFFFF; sbuf[i] = 4'hF; end
      do_write(0, 24'h20, 7, 2'b01, 8, 7, 0);
      for (int i = 0; i < 8; i++) begin wbuf[i] = i; sbuf[i] = (i % 2) ? 4'h3 : 4'hF; end
      do_write(0, 24'h20, 7, 2'b01, 8, 7, 1);
      do_read(0, 24'h20, 7, 2'b01, 1);
      for (int i = 0; i < 8; i++) begin
         check("t2_rdata", rbuf[i], (i % 2) ? (32'hFFFF0000 | i) : 32'(i));
         check("t2_rlast", rlast_buf[i], (i == 7));
      end

      // FIXED burst keeps hitting one word
      for (int i = 0; i < 4; i++) begin wbuf[i] = i + 1; sbuf[i] = 4'hF; end
      do_write(1, 24'h40, 3, 2'b00, 4, 3, 0);
      do_read(0, 24'h40, 0, 2'b01, 0);
      check("t3_fixed", rbuf[0], 32'd4);

      // INCR wraps past the top word; upper address bits alias
      wbuf[0] = 32'hA5A50001; wbuf[1] = 32'h5A5A0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
      do_write(0, 24'hFFC, 1, 2'b01, 2, 1, 0);
      do_read(0, 24'h000, 0, 2'b01, 0);
      check("t4_wrap_word0", rbuf[0], 32'h5A5A0002);
      do_read(1, 24'hFFFFFC, 0, 2'b10, 0);
      check("t4_alias_top", rbuf[0], 32'hA5A50001);
      do_read(0, 24'h7FFC, 1, 2'b11, 0);
      check("t4_rsvd_beat1", rbuf[1], 32'h5A5A0002);

      // early wlast and missing wlast both give SLVERR
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h11111110 + i; sbuf[i] = 4'hF; end
      do_write(0, 24'h80, 3, 2'b01, 4, 3, 0);
      wbuf[0] = 32'hE0; wbuf[1] = 32'hE1;
      do_write(1, 24'h80, 3, 2'b01, 2, 1, 0);
      check("t5_early_bresp", b_resp_got, 2'b10);
      wvalid = 1; wdata = 32'hBAD; wstrb = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); check("t5_wready_stall", wready, 0);
         @(posedge clk); #1;
      end
      wvalid = 0;
      do_read(0, 24'h80, 3, 2'b01, 0);
      check("t5_w0", rbuf[1], 32'hE1);
      check("t5_w2_kept", rbuf[2], 32'h11111112);
      do_write(0, 24'h90, 1, 2'b01, 2, -1, 0);
      check("t5_nolast_bresp", b_resp_got, 2'b10);

      // read-during-write on the fetch edge returns the old word
      wbuf[0] = 32'h0DD00000; sbuf[0] = 4'hF;
      do_write(0, 24'h100, 0, 2'b01, 1, 0, 0);
      awid = 0; awaddr = 24'h100; awlen = 0; awburst = 2'b01; awvalid = 1;
      t = 0;
      do begin @(negedge clk); t++; end while (!awready && t < TMO);
      check("t6_awready", awready, 1);
      @(posedge clk); #1 awvalid = 0;
      arid = 1; araddr = 24'h100; arlen = 0; arburst = 2'b01; arvalid = 1;
      @(negedge clk); check("t6_arready", arready, 1);
      @(posedge clk); #1 arvalid = 0; wvalid = 1; wdata = 32'h0EE00000; wstrb = 4'hF; wlast = 1;
      @(negedge clk); check("t6_wready", wready, 1);
      @(posedge clk); #1 wvalid = 0; wlast = 0; rready = 1; bready = 1;
      @(negedge clk);
      check("t6_rvalid", rvalid, 1);
      check("t6_old_data", rdata, 32'h0DD00000);
      check("t6_bvalid", bvalid, 1);
      @(posedge clk); #1 rready = 0; bready = 0;
      do_read(0, 24'h100, 0, 2'b01, 0);
      check("t6_new_data", rbuf[0], 32'h0EE00000);

      // reset in the middle of a read burst
      arid = 0; araddr = 24'h20; arlen = 7; arburst = 2'b01; arvalid = 1; rready = 0;
      t = 0;
      do begin @(negedge clk); t++; end while (!arready && t < TMO);
      @(posedge clk); #1 arvalid = 0;
      t = 0;
      do begin @(negedge clk); t++; end while (!rvalid && t < TMO);
      check("t8_rvalid_up", rvalid, 1);
      @(posedge clk); #2 arst_n = 0;
      #1 check("t8_rvalid_async_drop", rvalid, 0);
      @(negedge clk);
      @(posedge clk); #1 arst_n = 1;
      @(negedge clk); check("t8_arready_held", arready, 0);
      @(posedge clk); #1;
      @(negedge clk); check("t8_arready_back", arready, 1);
      @(posedge clk); #1;
      do_read(0, 24'h20, 7, 2'b01, 0);
      check("t8_ram_kept_b0", rbuf[0], 32'd0);
      check("t8_ram_kept_b7", rbuf[7], 32'hFFFF0007);

      // concurrent random traffic over a small aliased window
      fork
         begin
            for (int n = 0; n < 30; n++) begin
               int len;
               len = $urandom_range(0, 15);
               for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
               do_write(1'($urandom), 24'(($urandom & 32'hFFF000) | ($urandom_range(0, 63) << 2)
                        | $urandom_range(0, 3)), len, 2'($urandom_range(0, 3)), len + 1, len, 1);
            end
         end
         begin
            for (int n = 0; n < 30; n++) begin
               do_read(1'($urandom), 24'(($urandom & 32'hFFF000) | ($urandom_range(0, 63) << 2)),
                       $urandom_range(0, 15), 2'($urandom_range(0, 3)), 1);
            end
         end
      join

      repeat (4) @(posedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
